// File: rtl/sblk_pkg.sv
// Shared defaults and types for the sblk instruction/act scheduler.
//   N_SBLK_DEF     : number of sblk_ctrl instances served
//   WID_INST_DEF   : instruction width
//   FIFO_DEPTH_DEF : instruction FIFO entries (power of 2)
//   RSV_CYC        : cycles an issued sblk stays reserved without a status rise
//   disp_st_e      : dispatch FSM states
package sblk_pkg;
  localparam int N_SBLK_DEF     = 4;
  localparam int WID_INST_DEF   = 28;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RSV_CYC        = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } disp_st_e;
endpackage

// File: rtl/sblk_sched_inst_fifo.sv
// inst_fifo: synchronous instruction FIFO, count-based full/empty.
//   clk_l, rst_n : clock, async active-low reset (pointers/count only)
//   push/push_data : write strobe and data (caller gates with !full)
//   pop            : advance head (caller gates with !empty)
//   head           : current head entry
//   full, empty    : status decoded from the occupancy count
module inst_fifo
  import sblk_pkg::*;
#(
  parameter int WID   = WID_INST_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic           clk_l,
  input  logic           rst_n,
  input  logic           push,
  input  logic [WID-1:0] push_data,
  input  logic           pop,
  output logic [WID-1:0] head,
  output logic           full,
  output logic           empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WID-1:0] mem_q, mem_d;
  logic [AW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]               cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    // simultaneous push and pop leaves the occupancy unchanged
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // storage needs no reset: it is only read behind a non-zero count
  always_ff @(posedge clk_l) mem_q <= mem_d;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/sblk_sched.sv
// sblk_sched: queues host instructions and dispatches each to the lowest
// free sblk; round-robin arbitrates sblk act-batch requests for the loader.
//   inst_in_*      : host instruction push (valid/ready)
//   sblk_inst_data : last issued instruction, broadcast to all sblks
//   sblk_inst_en   : one-hot, one-cycle load pulse
//   sblk_status    : per-sblk busy
//   sblk_act_req   : per-sblk one-cycle batch request
//   act_grant_*    : current grant, held until act_done; act_sel steers act_in_vld
//   idle           : scheduler and all sblks quiescent
module sblk_sched
  import sblk_pkg::*;
#(
  parameter int N_SBLK     = N_SBLK_DEF,
  parameter int WID_INST   = WID_INST_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int WID_SBLK   = $clog2(N_SBLK)
) (
  input  logic                clk_l,
  input  logic                rst_n,
  input  logic [WID_INST-1:0] inst_in_data,
  input  logic                inst_in_vld,
  output logic                inst_in_rdy,
  output logic [WID_INST-1:0] sblk_inst_data,
  output logic [N_SBLK-1:0]   sblk_inst_en,
  input  logic [N_SBLK-1:0]   sblk_status,
  input  logic [N_SBLK-1:0]   sblk_act_req,
  output logic                act_grant_vld,
  output logic [WID_SBLK-1:0] act_grant_id,
  output logic [N_SBLK-1:0]   act_sel,
  input  logic                act_done,
  output logic                idle
);
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WID_INST-1:0] fifo_head;

  disp_st_e                 st_q, st_d;
  logic [N_SBLK-1:0]        en_q, en_d, rsv_q, rsv_d, stat_q, stat_d;
  logic [N_SBLK-1:0]        free, issue_oh, st_rise;
  logic [N_SBLK-1:0][2:0]   tmr_q, tmr_d;
  logic [WID_INST-1:0]      data_q, data_d;
  logic [N_SBLK-1:0]        pend_q, pend_d;
  logic                     gvld_q, gvld_d, rr_hit;
  logic [WID_SBLK-1:0]      gid_q, gid_d, last_q, last_d, rr_idx, rr_c;

  assign inst_in_rdy = ~fifo_full;
  assign fifo_push   = inst_in_vld & ~fifo_full;

  inst_fifo #(.WID(WID_INST), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_l     (clk_l),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (inst_in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- dispatch ----------------
  assign free     = ~sblk_status & ~rsv_q;
  assign issue_oh = free & (~free + N_SBLK'(1));  // lowest set bit
  assign stat_d   = sblk_status;
  assign st_rise  = sblk_status & ~stat_q;

  // target and data are chosen on the IDLE->ISSUE edge so the ISSUE cycle
  // drives registered outputs; the head is popped during ISSUE
  always_comb begin
    st_d     = st_q;
    en_d     = '0;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (st_q)
      ST_IDLE: if (!fifo_empty && |free) begin
        st_d   = ST_ISSUE;
        en_d   = issue_oh;
        data_d = fifo_head;
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        st_d     = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // reservation bridges the gap until the sblk reports busy; it drops on the
  // status rise or after RSV_CYC cycles, whichever comes first
  always_comb begin
    rsv_d = rsv_q;
    tmr_d = tmr_q;
    for (int i = 0; i < N_SBLK; i++) begin
      if (en_q[i]) begin
        rsv_d[i] = 1'b1;
        tmr_d[i] = 3'(RSV_CYC);
      end else if (rsv_q[i] && (st_rise[i] || tmr_q[i] == 3'd1)) begin
        rsv_d[i] = 1'b0;
      end else if (rsv_q[i]) begin
        tmr_d[i] = tmr_q[i] - 3'd1;
      end
    end
  end

  // ---------------- act arbiter ----------------
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_c   = '0;
    for (int o = 1; o <= N_SBLK; o++) begin
      rr_c = WID_SBLK'((int'(last_q) + o) % N_SBLK);
      if (!rr_hit && pend_q[rr_c]) begin
        rr_hit = 1'b1;
        rr_idx = rr_c;
      end
    end
  end

  // arbitration only runs while no grant is held, so the cycle after
  // act_done is always a dead cycle
  always_comb begin
    gvld_d = gvld_q;
    gid_d  = gid_q;
    last_d = last_q;
    pend_d = pend_q | sblk_act_req;
    if (gvld_q) begin
      if (act_done) gvld_d = 1'b0;
    end else if (rr_hit) begin
      gvld_d         = 1'b1;
      gid_d          = rr_idx;
      last_d         = rr_idx;
      pend_d[rr_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      en_q   <= '0;
      data_q <= '0;
      rsv_q  <= '0;
      tmr_q  <= '0;
      stat_q <= '0;
      pend_q <= '0;
      gvld_q <= 1'b0;
      gid_q  <= '0;
      last_q <= WID_SBLK'(N_SBLK - 1);
    end else begin
      st_q   <= st_d;
      en_q   <= en_d;
      data_q <= data_d;
      rsv_q  <= rsv_d;
      tmr_q  <= tmr_d;
      stat_q <= stat_d;
      pend_q <= pend_d;
      gvld_q <= gvld_d;
      gid_q  <= gid_d;
      last_q <= last_d;
    end
  end

  assign sblk_inst_en   = en_q;
  assign sblk_inst_data = data_q;
  assign act_grant_vld  = gvld_q;
  assign act_grant_id   = gid_q;
  assign act_sel        = gvld_q ? (N_SBLK'(1) << gid_q) : '0;
  assign idle           = fifo_empty && (st_q == ST_IDLE) && (sblk_status == '0) &&
                          (rsv_q == '0) && (pend_q == '0) && !gvld_q;
endmodule

// File: tb/tb_sblk_sched.sv
// Directed bench for sblk_sched: reset values, dispatch order and spacing,
// FIFO full stall, reservation timeout, round-robin act grants, async reset.
module tb_sblk_sched;
  localparam int N = 4;
  localparam int W = 28;

  logic         clk_l = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] inst_in_data = '0;
  logic         inst_in_vld = 1'b0;
  logic         inst_in_rdy;
  logic [W-1:0] sblk_inst_data;
  logic [N-1:0] sblk_inst_en;
  logic [N-1:0] sblk_status = '0;
  logic [N-1:0] sblk_act_req = '0;
  logic         act_grant_vld;
  logic [1:0]   act_grant_id;
  logic [N-1:0] act_sel;
  logic         act_done = 1'b0;
  logic         idle;

  int checks   = 0;
  int failures = 0;
  int npulse;
  logic [N-1:0] exp_sel;

  sblk_sched dut (
    .clk_l          (clk_l),
    .rst_n          (rst_n),
    .inst_in_data   (inst_in_data),
    .inst_in_vld    (inst_in_vld),
    .inst_in_rdy    (inst_in_rdy),
    .sblk_inst_data (sblk_inst_data),
    .sblk_inst_en   (sblk_inst_en),
    .sblk_status    (sblk_status),
    .sblk_act_req   (sblk_act_req),
    .act_grant_vld  (act_grant_vld),
    .act_grant_id   (act_grant_id),
    .act_sel        (act_sel),
    .act_done       (act_done),
    .idle           (idle)
  );

  always #5 clk_l = ~clk_l;

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset ----
    repeat (2) @(posedge clk_l);
    #1;
    chk("rst_en", 32'(sblk_inst_en), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", 32'(inst_in_rdy), 32'h1);
    chk("rst_data", 32'(sblk_inst_data), 32'h0);
    chk("rst_gvld", 32'(act_grant_vld), 32'h0);
    chk("rst_gid", 32'(act_grant_id), 32'h0);
    chk("rst_sel", 32'(act_sel), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);

    // ---- four instructions, all sblks free ----
    inst_in_vld = 1'b1; inst_in_data = 28'hA000001; tick();
    chk("d4_en0", 32'(sblk_inst_en), 32'h0);
    inst_in_data = 28'hA000002; tick();
    chk("d4_en1", 32'(sblk_inst_en), 32'h1);
    chk("d4_dat1", 32'(sblk_inst_data), 32'hA000001);
    inst_in_data = 28'hA000003; tick();
    chk("d4_gap1", 32'(sblk_inst_en), 32'h0);
    inst_in_data = 28'hA000004; tick();
    chk("d4_en2", 32'(sblk_inst_en), 32'h2);
    chk("d4_dat2", 32'(sblk_inst_data), 32'hA000002);
    chk("d4_rdy3", 32'(inst_in_rdy), 32'h1);
    inst_in_vld = 1'b0; tick();
    chk("d4_gap2", 32'(sblk_inst_en), 32'h0);
    tick();
    chk("d4_en4", 32'(sblk_inst_en), 32'h4);
    chk("d4_dat3", 32'(sblk_inst_data), 32'hA000003);
    tick();
    chk("d4_gap3", 32'(sblk_inst_en), 32'h0);
    tick();
    chk("d4_en8", 32'(sblk_inst_en), 32'h8);
    chk("d4_dat4", 32'(sblk_inst_data), 32'hA000004);
    tick();
    chk("d4_hold", 32'(sblk_inst_data), 32'hA000004);
    chk("d4_en_off", 32'(sblk_inst_en), 32'h0);
    repeat (6) tick();
    chk("d4_rsv_last", 32'(idle), 32'h0);
    tick();
    chk("d4_idle", 32'(idle), 32'h1);

    // ---- five instructions, all busy: FIFO full stall ----
    sblk_status = 4'hF; inst_in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_in_data = 28'hB000000 + 28'(i);
      tick();
    end
    inst_in_data = 28'hB000004;
    chk("full_rdy", 32'(inst_in_rdy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_rdy_hold", 32'(inst_in_rdy), 32'h0);
      chk("full_no_en", 32'(sblk_inst_en), 32'h0);
    end
    sblk_status = 4'b1011; tick();
    chk("full_en2", 32'(sblk_inst_en), 32'h4);
    chk("full_dat", 32'(sblk_inst_data), 32'hB000000);
    tick();
    chk("full_rdy_back", 32'(inst_in_rdy), 32'h1);
    tick();
    inst_in_vld = 1'b0; sblk_status = '0;
    npulse = 0;
    repeat (30) begin
      tick();
      npulse += $countones(sblk_inst_en);
    end
    chk("full_drain_cnt", 32'(npulse), 32'd4);
    chk("full_idle", 32'(idle), 32'h1);

    // ---- reservation timeout on sblk0 ----
    sblk_status = 4'b1110; inst_in_vld = 1'b1; inst_in_data = 28'hC000001; tick();
    inst_in_data = 28'hC000002; tick();
    inst_in_vld = 1'b0;
    chk("rsv_en0", 32'(sblk_inst_en), 32'h1);
    chk("rsv_dat0", 32'(sblk_inst_data), 32'hC000001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rsv_blocked", 32'(sblk_inst_en), 32'h0);
    end
    tick();
    chk("rsv_reissue", 32'(sblk_inst_en), 32'h1);
    chk("rsv_dat1", 32'(sblk_inst_data), 32'hC000002);
    sblk_status = '0;
    repeat (10) tick();
    chk("rsv_idle", 32'(idle), 32'h1);

    // ---- stray act_done ignored ----
    act_done = 1'b1; tick(); act_done = 1'b0;
    chk("stray_done_gvld", 32'(act_grant_vld), 32'h0);
    chk("stray_done_idle", 32'(idle), 32'h1);

    // ---- all four request together: 0,1,2,3 with dead cycles ----
    sblk_act_req = 4'hF; tick(); sblk_act_req = '0;
    chk("rr_pre_gvld", 32'(act_grant_vld), 32'h0);
    chk("rr_pre_idle", 32'(idle), 32'h0);
    for (int g = 0; g < 4; g++) begin
      exp_sel = 4'(1 << g);
      tick();
      chk("rr_gvld", 32'(act_grant_vld), 32'h1);
      chk("rr_id", 32'(act_grant_id), 32'(g));
      chk("rr_sel", 32'(act_sel), 32'(exp_sel));
      tick();
      chk("rr_hold", 32'(act_grant_vld), 32'h1);
      act_done = 1'b1; tick(); act_done = 1'b0;
      chk("rr_dead", 32'(act_grant_vld), 32'h0);
      chk("rr_dead_sel", 32'(act_sel), 32'h0);
    end
    chk("rr_idle", 32'(idle), 32'h1);

    // ---- re-request from granted sblk goes behind others ----
    sblk_act_req = 4'b0011; tick(); sblk_act_req = '0;
    tick();
    chk("rereq_g0", 32'(act_grant_id), 32'h0);
    chk("rereq_v0", 32'(act_grant_vld), 32'h1);
    sblk_act_req = 4'b0001; tick(); sblk_act_req = '0;
    act_done = 1'b1; tick(); act_done = 1'b0;
    tick();
    chk("rereq_g1", 32'(act_grant_id), 32'h1);
    act_done = 1'b1; tick(); act_done = 1'b0;
    tick();
    chk("rereq_v2", 32'(act_grant_vld), 32'h1);
    chk("rereq_g2", 32'(act_grant_id), 32'h0);
    act_done = 1'b1; tick(); act_done = 1'b0;
    chk("rereq_end", 32'(act_grant_vld), 32'h0);
    chk("rereq_idle", 32'(idle), 32'h1);

    // ---- async reset during grant of id 2 ----
    sblk_act_req = 4'b0100; tick(); sblk_act_req = '0;
    tick();
    chk("ar_gvld", 32'(act_grant_vld), 32'h1);
    chk("ar_gid", 32'(act_grant_id), 32'h2);
    chk("ar_sel", 32'(act_sel), 32'h4);
    sblk_act_req = 4'b1000; tick(); sblk_act_req = '0;
    chk("ar_busy", 32'(idle), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel0", 32'(act_sel), 32'h0);
    chk("ar_gvld0", 32'(act_grant_vld), 32'h0);
    chk("ar_idle", 32'(idle), 32'h1);
    chk("ar_en0", 32'(sblk_inst_en), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_post_idle", 32'(idle), 32'h1);
    chk("ar_post_gvld", 32'(act_grant_vld), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
